// File: rtl/add_sub_serial.sv
// add_sub_serial: digit-serial adder/subtractor with N/Z/C/V flags.
//
// A CHUNK-bit adder is reused over N = WIDTH/CHUNK cycles. Operands are
// captured on acceptance, and the result plus flags are loaded on the edge
// that processes the last chunk. The result is then held until the consumer
// accepts it.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active-high
//   in_valid   operand request
//   in_ready   operand accept (high only in IDLE)
//   a, b       operands, WIDTH bits
//   in_c       0 = a+b, 1 = a-b; also the carry-in
//   out_valid  result available (DONE)
//   out_ready  consumer accepts the result
//   s          result, WIDTH bits
//   out_c      carry out of MSB (subtract: 1 = no borrow)
//   overflow   signed overflow
//   zero       s == 0
//   negative   s[WIDTH-1]
module add_sub_serial #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             out_c,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("add_sub_serial: WIDTH must be a nonzero multiple of CHUNK");
    end

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q;      // shifts right one chunk per RUN cycle
    logic [WIDTH-1:0]   b_q;      // already inverted for subtract
    logic [WIDTH-1:0]   res_q;    // chunk sums enter at the top
    logic [WIDTH-1:0]   res_d;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               zacc_q;   // stays 1 while every chunk sum so far is zero

    logic               accept;
    logic               last_chunk;
    logic [CHUNK:0]     chunk_sum;
    logic [CHUNK-1:0]   sum_bits;
    logic               carry_out;
    logic               carry_into_msb;

    assign accept     = in_valid && (state_q == StIdle);
    assign last_chunk = (cnt_q == CNT_W'(N - 1));

    // Narrow adder shared across all chunks.
    assign chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, carry_q};
    assign sum_bits  = chunk_sum[CHUNK-1:0];
    assign carry_out = chunk_sum[CHUNK];

    // On the last chunk the carry into the MSB is recovered from the MSB's
    // own sum bit: sum = a ^ b ^ cin, so cin = a ^ b ^ sum.
    assign carry_into_msb = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ sum_bits[CHUNK-1];

    // Written as shifts so that CHUNK == WIDTH needs no special case.
    assign res_d = (res_q >> CHUNK) | (WIDTH'(sum_bits) << (WIDTH - CHUNK));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid)  state_d = StRun;
            StRun:   if (last_chunk) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs.
    always_comb begin
        in_ready  = (state_q == StIdle) && !rst;
        out_valid = (state_q == StDone);
    end

    // Datapath and registered result/flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            zacc_q   <= 1'b0;
            s        <= '0;
            out_c    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{in_c}};
            res_q   <= '0;
            carry_q <= in_c;
            cnt_q   <= '0;
            zacc_q  <= 1'b1;
        end else if (state_q == StRun) begin
            a_q     <= a_q >> CHUNK;
            b_q     <= b_q >> CHUNK;
            res_q   <= res_d;
            carry_q <= carry_out;
            cnt_q   <= cnt_q + CNT_W'(1);
            zacc_q  <= zacc_q && (sum_bits == '0);
            if (last_chunk) begin
                s        <= res_d;
                out_c    <= carry_out;
                overflow <= carry_into_msb ^ carry_out;
                zero     <= zacc_q && (sum_bits == '0);
                negative <= sum_bits[CHUNK-1];
            end
        end
    end

endmodule
